// File: rtl/dm_host_if.sv
// Bus bundle between the data-memory host sequencer and its environment
// (image source, result sink, data memory port, processor status lines).
interface dm_host_if #(
  parameter int ADDR_W = 20
);
  // Streams use valid/ready: a byte moves on every rising edge where valid
  // and ready are both high; the sender holds data stable while valid && !ready.
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] dm_addr;
  logic [7:0]        dm_wdata;
  logic              dm_we;
  logic              dm_rd;
  logic [7:0]        dm_rdata;
  logic              end_process;
  logic [1:0]        status;
  logic              done;
  logic              err;

  modport master (
    input  start, in_data, in_valid, out_ready, dm_rdata, end_process,
    output in_ready, out_data, out_valid, dm_addr, dm_wdata, dm_we, dm_rd,
           status, done, err
  );

  modport slave (
    output start, in_data, in_valid, out_ready, dm_rdata, end_process,
    input  in_ready, out_data, out_valid, dm_addr, dm_wdata, dm_we, dm_rd,
           status, done, err
  );
endinterface

// File: rtl/dm_host_ctrl.sv
// Host sequencer: load image into data memory, hand memory to the processor,
// then stream the result back out. Optional run watchdog: DMH_TIMEOUT_EN.
module dm_host_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int IMG_BYTES   = 65536,
  parameter int OUT_BYTES   = 16384,
  parameter int OUT_BASE    = 65536,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clock,
  input  logic       rst_n,
  dm_host_if.master  bus,
  output logic [1:0] state_dbg
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] IMG_LAST = CW'(IMG_BYTES - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BYTES - 1);
  localparam logic [CW-1:0] OUT_END  = CW'(OUT_BYTES);
  localparam logic [CW-1:0] OUT_BASE_C = CW'(OUT_BASE);

  // State encoding doubles as the status code seen by the memory mux.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b10,
    S_RUN    = 2'b01,
    S_UNLOAD = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] ld_cnt;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] rd_issued;
  logic [CW-1:0] out_cnt;
  logic          armed;
  logic          inflight;
  logic [7:0]    fifo_mem [2];
  logic          fifo_wp;
  logic          fifo_rp;
  logic [1:0]    fifo_cnt;
  logic [1:0]    occ;

  logic accept, issue, pop, push, last_out, run_done, timeout;

  assign accept   = (state == S_LOAD) && bus.in_valid;
  assign pop      = (fifo_cnt != 2'd0) && bus.out_ready;
  assign push     = inflight;
  assign occ      = fifo_cnt + {1'b0, inflight};
  assign last_out = (state == S_UNLOAD) && pop && (out_cnt == OUT_LAST);
  assign run_done = (state == S_RUN) && armed && bus.end_process;
  // A pop this cycle frees a slot, so a read may issue against it; this keeps
  // one byte per cycle with out_ready held high without ever overflowing.
  assign issue    = (state == S_UNLOAD) && (rd_issued < OUT_END) &&
                    (occ < (2'd2 + {1'b0, pop}));
  assign state_dbg = state;

`ifdef DMH_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] run_cnt;
  logic        err_q;

  assign timeout = (state == S_RUN) && !run_done && (run_cnt == TO_LAST);
  assign bus.err = err_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      run_cnt <= (state == S_RUN) ? run_cnt + 32'd1 : 32'd0;
      if ((state == S_IDLE) && bus.start) err_q <= 1'b0;
      else if (timeout)                   err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_LOAD;
      S_LOAD:   if (accept && (ld_cnt == IMG_LAST)) state_nxt = S_RUN;
      S_RUN: begin
        if (run_done)     state_nxt = S_UNLOAD;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_UNLOAD: if (last_out) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.status    = state;
    bus.in_ready  = (state == S_LOAD);
    bus.dm_we     = accept;
    bus.dm_rd     = issue;
    bus.dm_wdata  = 8'd0;
    bus.dm_addr   = '0;
    bus.out_valid = (fifo_cnt != 2'd0);
    bus.out_data  = 8'd0;
    bus.done      = last_out;
    if (accept) begin
      bus.dm_addr  = ld_cnt[ADDR_W-1:0];
      bus.dm_wdata = bus.in_data;
    end else if (issue) begin
      bus.dm_addr  = rd_ptr[ADDR_W-1:0];
    end
    if (fifo_cnt != 2'd0) bus.out_data = fifo_mem[fifo_rp];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt      <= '0;
      rd_ptr      <= '0;
      rd_issued   <= '0;
      out_cnt     <= '0;
      armed       <= 1'b0;
      inflight    <= 1'b0;
      fifo_mem[0] <= 8'd0;
      fifo_mem[1] <= 8'd0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if ((state == S_IDLE) && bus.start) ld_cnt <= '0;
      else if (accept)                    ld_cnt <= ld_cnt + 1'b1;

      // Arming on a low level first ignores a completion flag left high.
      if (state != S_RUN)        armed <= 1'b0;
      else if (!bus.end_process) armed <= 1'b1;

      if (run_done) begin
        rd_ptr    <= OUT_BASE_C;
        rd_issued <= '0;
        out_cnt   <= '0;
      end else begin
        if (issue) begin
          rd_ptr    <= rd_ptr + 1'b1;
          rd_issued <= rd_issued + 1'b1;
        end
        if (pop) out_cnt <= out_cnt + 1'b1;
      end

      inflight <= issue;
      if (push) begin
        fifo_mem[fifo_wp] <= bus.dm_rdata;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dm_host_ctrl.sv
// Directed bench for dm_host_ctrl with a behavioural data memory and a
// negedge monitor feeding write/output queues that the main sequence checks.
module tb_dm_host_ctrl;
  localparam int ADDR_W = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  dm_host_if #(.ADDR_W(ADDR_W)) bus ();
  logic [1:0] state_dbg;

  dm_host_ctrl #(
    .ADDR_W(ADDR_W), .IMG_BYTES(16), .OUT_BYTES(4), .OUT_BASE(16), .TIMEOUT_CYC(8)
  ) dut (
    .clock(clock), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]        mem [0:255];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];
  logic [7:0]        out_q[$];
  int                out_cyc_q[$];
  logic              done_q[$];
  logic [7:0]        exp_q[$];
  int issued_tot, popped_tot, viol, done_cnt, stray_done, first_rd_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  // Data memory: result area preloaded during reset, 1-cycle read latency.
  always @(posedge clock) begin
    if (!rst_n) begin
      mem[16] <= 8'h11; mem[17] <= 8'h22; mem[18] <= 8'h33; mem[19] <= 8'h44;
    end else begin
      if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wdata;
      if (bus.dm_rd) bus.dm_rdata <= mem[bus.dm_addr];
    end
  end

  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.dm_we) begin
        wr_addr_q.push_back(bus.dm_addr);
        wr_data_q.push_back(bus.dm_wdata);
      end
      if (bus.dm_rd) begin
        if (issued_tot == 0) first_rd_cyc = cyc;
        issued_tot++;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data);
        out_cyc_q.push_back(cyc);
        done_q.push_back(bus.done);
        popped_tot++;
      end
      if (bus.done) begin
        done_cnt++;
        if (!(bus.out_valid && bus.out_ready)) stray_done++;
      end
      if (issued_tot - popped_tot > 2) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete();
    out_q.delete(); out_cyc_q.delete(); done_q.delete();
    issued_tot = 0; popped_tot = 0; viol = 0;
    done_cnt = 0; stray_done = 0; first_rd_cyc = -1;
  endtask

  // Start a frame and feed 16 bytes base..base+15, idling every third cycle
  // and pulsing start once mid-load (must be ignored).
  task automatic do_load(input logic [7:0] base);
    int k;
    int c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("in_ready_after_start", bus.in_ready, 1);
    chk("status_load", bus.status, 2'b10);
    k = 0;
    c = 0;
    while (k < 16 && c < 100) begin
      bus.in_valid = (c % 3 != 2);
      bus.in_data  = base + 8'(k);
      bus.start    = (c == 2);
      step();
      if (bus.in_valid) k++;
      c++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    #1;
    chk("status_run_after_load", bus.status, 2'b01);
    chk("load_write_count", wr_addr_q.size(), 16);
    while (wr_addr_q.size() < 16) begin
      wr_addr_q.push_back('x);
      wr_data_q.push_back('x);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("load_addr_%0d", i), wr_addr_q[i], i);
      chk($sformatf("load_data_%0d", i), wr_data_q[i], base + 8'(i));
    end
  endtask

  task automatic check_outputs(input string tag, input bit strict_timing);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_out_count"}, out_q.size(), 4);
    chk({tag, "_outstanding_viol"}, viol, 0);
    chk({tag, "_stray_done"}, stray_done, 0);
    while (out_q.size() < 4) begin
      out_q.push_back('x);
      out_cyc_q.push_back(-1);
      done_q.push_back(1'bx);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_data_%0d", tag, i), out_q[i], exp_q[i]);
      chk($sformatf("%s_done_%0d", tag, i), done_q[i], (i == 3));
      if (strict_timing)
        chk($sformatf("%s_cycle_%0d", tag, i), out_cyc_q[i], first_rd_cyc + 2 + i);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_data = 8'd0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b0; bus.end_process = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_mon();

    // Reset values
    rst_n = 1'b0;
    step(); step();
    chk("rst_status", bus.status, 2'b00);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dm_we", bus.dm_we, 0);
    chk("rst_dm_rd", bus.dm_rd, 0);
    chk("rst_dm_addr", bus.dm_addr, 0);
    chk("rst_dm_wdata", bus.dm_wdata, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_state_dbg", state_dbg, 2'b00);
    rst_n = 1'b1;
    step();

    // in_valid outside LOAD is ignored
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    #1;
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_dm_we", bus.dm_we, 0);
    bus.in_valid = 1'b0;
    step();

    // Frame 1: load, arm, end_process pulse, full-rate unload
    clear_mon();
    do_load(8'hA0);
    bus.in_valid = 1'b1;
    #1;
    chk("run_in_ready", bus.in_ready, 0);
    chk("run_dm_we", bus.dm_we, 0);
    chk("run_dm_rd", bus.dm_rd, 0);
    chk("run_dm_addr", bus.dm_addr, 0);
    bus.in_valid = 1'b0;
    step();
    bus.end_process = 1'b1;
    step();
    bus.end_process = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("unload_status", bus.status, 2'b11);
    chk("unload_first_rd", bus.dm_rd, 1);
    chk("unload_first_addr", bus.dm_addr, 16);
    for (int i = 0; i < 20 && done_cnt == 0; i++) step();
    chk("f1_status_after_done", bus.status, 2'b00);
    chk("f1_out_valid_after_done", bus.out_valid, 0);
    check_outputs("f1", 1'b1);

    // Frame 2: stale end_process high on RUN entry, random backpressure
    clear_mon();
    bus.out_ready = 1'b0;
    bus.end_process = 1'b1;
    do_load(8'h50);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stale_status_%0d", i), bus.status, 2'b01);
      chk($sformatf("stale_dm_rd_%0d", i), bus.dm_rd, 0);
      step();
    end
    chk("stale_status_3", bus.status, 2'b01);
    bus.end_process = 1'b0;
    step();
    chk("stale_status_armed", bus.status, 2'b01);
    bus.end_process = 1'b1;
    step();
    bus.end_process = 1'b0;
    chk("f2_unload_status", bus.status, 2'b11);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.out_ready = 1'b0;
    chk("f2_status_after_done", bus.status, 2'b00);
    check_outputs("f2", 1'b0);

    // Frame 3: reset pulsed mid-unload with the FIFO holding data
    clear_mon();
    do_load(8'h70);
    step();
    bus.end_process = 1'b1;
    step();
    bus.end_process = 1'b0;
    step(); step(); step();
    chk("f3_fifo_filled", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_status", bus.status, 2'b00);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_dm_rd", bus.dm_rd, 0);
    chk("abort_out_data", bus.out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_abort_status", bus.status, 2'b00);
    chk("post_abort_out_valid", bus.out_valid, 0);

    // Frame 4: no completion from the processor
    clear_mon();
    do_load(8'h90);
`ifdef DMH_TIMEOUT_EN
    repeat (7) step();
    chk("wd_status_cycle8", bus.status, 2'b01);
    chk("wd_err_cycle8", bus.err, 0);
    step();
    chk("wd_status_abort", bus.status, 2'b00);
    chk("wd_err_set", bus.err, 1);
    chk("wd_no_done", done_cnt, 0);
    chk("wd_no_reads", issued_tot, 0);
    step();
    chk("wd_err_sticky", bus.err, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("wd_err_cleared", bus.err, 0);
    chk("wd_restart_status", bus.status, 2'b10);
`else
    repeat (12) step();
    chk("nowd_status_run", bus.status, 2'b01);
    chk("nowd_err", bus.err, 0);
    chk("nowd_no_reads", issued_tot, 0);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
